multicycle_sequencer: RTL

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer_pkg.sv | 27 ++
 rtl/multicycle_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle instruction sequencer: state
// encoding, branch-type codes, PC source select codes and the command width.
package multicycle_sequencer_pkg;

    localparam int EXEC_CMD_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE  = 2'b00,
        BR_ZERO  = 2'b01,
        BR_NZERO = 2'b10,
        BR_JUMP  = 2'b11
    } branch_t;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: walks FETCH -> DECODE -> EXEC ->
// [MEM] -> [WB] per instruction and emits the datapath strobes.
//
// Ports:
//   clk, rst_n            single clock, async active-low reset
//   start                 run enable (sampled in IDLE and at retire)
//   exec_command .. branch_type   decoded instruction fields
//   alu_zero, mem_ready   datapath feedback
//   imem_req .. reg_write datapath strobes; alu_cmd/pc_src selects
//   state, busy           FSM status
//   illegal_op, timeout_err   sticky error flags
//   retired               wrapping retired-instruction count
//
// Build option: MULTICYCLE_SEQ_MEM_TIMEOUT_EN bounds FETCH/MEM waits to
// TIMEOUT_CYCLES; when undefined waits are unbounded and timeout_err is 0.
//
// state  | meaning
// IDLE   | stopped, waiting for start
// FETCH  | instruction memory request until mem_ready
// DECODE | latch decoded fields
// EXEC   | ALU operation, branch resolution
// MEM    | data memory request until mem_ready
// WB     | register write-back
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [EXEC_CMD_W-1:0] exec_command,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  wb_enable,
    input  logic                  is_immediate,
    input  logic [1:0]            branch_type,
    input  logic                  alu_zero,
    input  logic                  mem_ready,
    output logic                  imem_req,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  alu_start,
    output logic                  alu_src_imm,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic                  reg_write,
    output logic [EXEC_CMD_W-1:0] alu_cmd,
    output logic [1:0]            pc_src,
    output logic [2:0]            state,
    output logic                  busy,
    output logic                  illegal_op,
    output logic                  timeout_err,
    output logic [15:0]           retired
);

    state_t                  state_q, state_d;
    logic [EXEC_CMD_W-1:0]   cmd_q, cmd_d;
    logic                    rd_q, rd_d, wr_q, wr_d, wb_q, wb_d, imm_q, imm_d;
    logic [1:0]              br_q, br_d;
    logic [15:0]             retired_q, retired_d;
    logic                    illegal_q, illegal_d;
    logic                    retire;

`ifdef MULTICYCLE_SEQ_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT_CYCLES - 1);
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic              wait_expired;

    // Down-counter reloads on every state change, so each FETCH/MEM visit
    // gets a full TIMEOUT_CYCLES budget; zero in a waiting cycle means expiry.
    assign wait_expired = (wait_cnt_q == '0);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = WAIT_LOAD;
        end else if ((state_q == ST_FETCH || state_q == ST_MEM) && !wait_expired) begin
            wait_cnt_d = wait_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= WAIT_LOAD;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        wb_d        = wb_q;
        imm_d       = imm_q;
        br_d        = br_q;
        retired_d   = retired_q;
        illegal_d   = illegal_q;
        retire      = 1'b0;
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        alu_start   = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_write   = 1'b0;
        pc_src      = PC_SRC_SEQ;
`ifdef MULTICYCLE_SEQ_MEM_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else begin
`ifdef MULTICYCLE_SEQ_MEM_TIMEOUT_EN
                    if (wait_expired) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
`endif
                end
            end
            ST_DECODE: begin
                cmd_d   = exec_command;
                rd_d    = mem_read;
                wr_d    = mem_write;
                wb_d    = wb_enable;
                imm_d   = is_immediate;
                br_d    = branch_type;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                alu_start = 1'b1;
                // Conflicting decode: flag it and retire without touching
                // memory, the register file or the PC.
                if ((rd_q && wr_q) || (br_q != BR_NONE && (rd_q || wr_q))) begin
                    illegal_d = 1'b1;
                    retire    = 1'b1;
                end else begin
                    case (br_q)
                        BR_ZERO: begin
                            if (alu_zero) begin
                                pc_write = 1'b1;
                                pc_src   = PC_SRC_BRANCH;
                            end
                            retire = 1'b1;
                        end
                        BR_NZERO: begin
                            if (!alu_zero) begin
                                pc_write = 1'b1;
                                pc_src   = PC_SRC_BRANCH;
                            end
                            retire = 1'b1;
                        end
                        BR_JUMP: begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_JUMP;
                            retire   = 1'b1;
                        end
                        default: begin
                            if (rd_q || wr_q) state_d = ST_MEM;
                            else if (wb_q)    state_d = ST_WB;
                            else              retire  = 1'b1;
                        end
                    endcase
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = wr_q;
                if (mem_ready) begin
                    if (wb_q) state_d = ST_WB;
                    else      retire  = 1'b1;
                end else begin
`ifdef MULTICYCLE_SEQ_MEM_TIMEOUT_EN
                    if (wait_expired) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
`endif
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (retire) begin
            retired_d = retired_q + 16'd1;
            state_d   = start ? ST_FETCH : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wb_q      <= 1'b0;
            imm_q     <= 1'b0;
            br_q      <= BR_NONE;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            wb_q      <= wb_d;
            imm_q     <= imm_d;
            br_q      <= br_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    assign alu_cmd     = cmd_q;
    assign alu_src_imm = imm_q;
    assign state       = state_q;
    assign busy        = (state_q != ST_IDLE);
    assign illegal_op  = illegal_q;
    assign retired     = retired_q;

endmodule
